// File: rtl/demod_pkg.sv
// Shared types and constants for the AM demodulator control slice.
// Holds state encoding, default tuning and datapath field widths.
package demod_pkg;

  localparam int PHI_W = 32;
  localparam int DEC_W = 16;

  localparam logic [PHI_W-1:0] DEFAULT_PHI = 32'd343597384;
  localparam logic [DEC_W-1:0] DEFAULT_DEC = 16'd125;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  function automatic logic cfg_legal(
    input logic [PHI_W-1:0] phi,
    input logic [DEC_W-1:0] dec,
    input logic [DEC_W-1:0] lo,
    input logic [DEC_W-1:0] hi
  );
    return (phi != '0) && (dec >= lo) && (dec <= hi);
  endfunction

endpackage

// File: rtl/demod_ctrl_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for a slow async strobe.
// The pulse is seen by the consuming flop on the third clk edge after the rise.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/demod_ctrl.sv
// Retune sequencer for the NCO/CIC/FIR demodulator datapath.
// Flushes the datapath, waits for the FIR to settle, then serves requests.
module demod_ctrl
  import demod_pkg::*;
#(
  parameter logic [PHI_W-1:0] DEF_PHI        = DEFAULT_PHI,
  parameter logic [DEC_W-1:0] DEF_DEC        = DEFAULT_DEC,
  parameter int               MIN_DEC        = 8,
  parameter int               MAX_DEC        = 1024,
  parameter int               FLUSH_CYCLES   = 16,
  parameter int               SETTLE_SAMPLES = 4,
  parameter int               TIMEOUT        = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PHI_W-1:0] cfg_phi_inc,
  input  logic [DEC_W-1:0] cfg_dec_ratio,
  input  logic             demod_clk_in,
  output logic             dp_rst,
  output logic [PHI_W-1:0] phi_inc,
  output logic [DEC_W-1:0] dec_ratio,
  output logic             demod_valid,
  output logic             cfg_err,
  output logic             timeout_err,
  output logic [1:0]       state_o
);

  localparam int CNT_W = 16;
  localparam int ECN_W = 8;

  localparam logic [CNT_W-1:0] FLUSH_LAST =
    CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [ECN_W-1:0] SETTLE_LAST =
    ECN_W'(SETTLE_SAMPLES - 1);
  localparam logic [DEC_W-1:0] DEC_LO = DEC_W'(MIN_DEC);
  localparam logic [DEC_W-1:0] DEC_HI = DEC_W'(MAX_DEC);

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [ECN_W-1:0] edge_cnt;
  logic             dclk_rise;
  logic             req_ok;

  edge_sync u_dclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (demod_clk_in),
    .rise     (dclk_rise)
  );

  assign req_ok =
    cfg_legal(cfg_phi_inc, cfg_dec_ratio, DEC_LO, DEC_HI);

  assign state_o = state;

  // cyc_cnt times both the flush hold and the settle watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FLUSH;
      dp_rst      <= 1'b1;
      phi_inc     <= DEF_PHI;
      dec_ratio   <= DEF_DEC;
      demod_valid <= 1'b0;
      cfg_ready   <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      cyc_cnt     <= '0;
      edge_cnt    <= '0;
    end else begin
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        ST_FLUSH: begin
          if (cyc_cnt == FLUSH_LAST) begin
            state    <= ST_SETTLE;
            dp_rst   <= 1'b0;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (dclk_rise) begin
            cyc_cnt  <= '0;
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == SETTLE_LAST) begin
              state       <= ST_RUN;
              demod_valid <= 1'b1;
              cfg_ready   <= 1'b1;
              edge_cnt    <= '0;
            end
          end else if (cyc_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_FLUSH;
            dp_rst      <= 1'b1;
            cyc_cnt     <= '0;
            edge_cnt    <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (cfg_valid) begin
            if (req_ok) begin
              phi_inc     <= cfg_phi_inc;
              dec_ratio   <= cfg_dec_ratio;
              state       <= ST_FLUSH;
              dp_rst      <= 1'b1;
              demod_valid <= 1'b0;
              cfg_ready   <= 1'b0;
              cyc_cnt     <= '0;
              edge_cnt    <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_FLUSH;
          dp_rst      <= 1'b1;
          demod_valid <= 1'b0;
          cfg_ready   <= 1'b0;
          cyc_cnt     <= '0;
          edge_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demod_ctrl.sv
// Directed bench for demod_ctrl with an event-level reference model.
// Model tracks deadlines and edge counts; compare runs every negedge.
module tb_demod_ctrl;

  localparam logic [31:0] D_PHI = 32'd343597384;
  localparam logic [15:0] D_DEC = 16'd125;
  localparam int M_FLUSH  = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_phi_inc = '0;
  logic [15:0] cfg_dec_ratio = '0;
  logic        demod_clk_in = 1'b0;
  logic        dp_rst;
  logic [31:0] phi_inc;
  logic [15:0] dec_ratio;
  logic        demod_valid;
  logic        cfg_err;
  logic        timeout_err;
  logic [1:0]  state_o;

  int n_chk  = 0;
  int n_pass = 0;

  demod_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_phi_inc   (cfg_phi_inc),
    .cfg_dec_ratio (cfg_dec_ratio),
    .demod_clk_in  (demod_clk_in),
    .dp_rst        (dp_rst),
    .phi_inc       (phi_inc),
    .dec_ratio     (dec_ratio),
    .demod_valid   (demod_valid),
    .cfg_err       (cfg_err),
    .timeout_err   (timeout_err),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // demod_clk source: toggles every 250 clk cycles while enabled
  bit dclk_run = 1'b1;
  int dcnt = 0;
  always @(posedge clk) begin
    #1;
    if (dclk_run) begin
      if (dcnt == 249) begin
        demod_clk_in = ~demod_clk_in;
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end
  end

  // reference model: deadlines in absolute cycle numbers
  int          cyc = 0;
  int          flush_exit = 0;
  int          last_ref = 0;
  int          edges = 0;
  int          xfers = 0;
  int          m_state = M_FLUSH;
  logic [31:0] m_phi = D_PHI;
  logic [15:0] m_dec = D_DEC;
  bit          m_cerr = 1'b0;
  bit          m_terr = 1'b0;
  bit          m_seen = 1'b0;
  bit          h0 = 1'b0;
  bit          h1 = 1'b0;
  bit          h2 = 1'b0;
  bit          det;
  bit          legal;

  always @(posedge clk) begin
    cyc++;
    det = h1 && !h2;
    m_cerr = 1'b0;
    m_terr = 1'b0;
    if (rst) begin
      m_seen = 1'b1;
      m_state = M_FLUSH;
      m_phi = D_PHI;
      m_dec = D_DEC;
      flush_exit = cyc + 16;
      h0 = 1'b0;
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = h0;
      h0 = demod_clk_in;
      case (m_state)
        M_FLUSH: if (cyc == flush_exit) begin
          m_state = M_SETTLE;
          edges = 0;
          last_ref = cyc;
        end
        M_SETTLE: if (det) begin
          edges++;
          last_ref = cyc;
          if (edges == 4) m_state = M_RUN;
        end else if (cyc - last_ref == 4096) begin
          m_terr = 1'b1;
          m_state = M_FLUSH;
          flush_exit = cyc + 16;
        end
        default: if (cfg_valid) begin
          legal = (cfg_phi_inc != 0) && (cfg_dec_ratio >= 8)
                  && (cfg_dec_ratio <= 1024);
          if (legal) begin
            m_phi = cfg_phi_inc;
            m_dec = cfg_dec_ratio;
            m_state = M_FLUSH;
            flush_exit = cyc + 16;
            xfers++;
          end else begin
            m_cerr = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_seen) begin
      check("state_o", 32'(state_o), 32'(m_state));
      check("dp_rst", 32'(dp_rst), 32'(m_state == M_FLUSH));
      check("demod_valid", 32'(demod_valid), 32'(m_state == M_RUN));
      check("cfg_ready", 32'(cfg_ready), 32'(m_state == M_RUN));
      check("phi_inc", phi_inc, m_phi);
      check("dec_ratio", 32'(dec_ratio), 32'(m_dec));
      check("cfg_err", 32'(cfg_err), 32'(m_cerr));
      check("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic wait_state(input int st, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (m_state == st) hit = 1'b1;
    end
    check("wait_state", 32'(hit), 32'd1);
  endtask

  task automatic send(input logic [31:0] p, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_phi_inc = p;
    cfg_dec_ratio = d;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic count_flush(input string nm);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (dp_rst) n++;
      else done = 1'b1;
    end
    check(nm, 32'(n), 32'd16);
  endtask

  initial begin
    int n;
    int k;
    bit done;
    int x0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_phi", phi_inc, 32'd343597384);
    check("rst_dec", 32'(dec_ratio), 32'd125);
    check("rst_valid", 32'(demod_valid), 32'd0);
    count_flush("flush_len_boot");
    wait_state(M_RUN, 5000);
    check("boot_valid", 32'(demod_valid), 32'd1);
    check("boot_edges", 32'(edges), 32'd4);

    // accepted retune
    send(32'd171798692, 16'd250);
    check("rt_phi", phi_inc, 32'd171798692);
    check("rt_dec", 32'(dec_ratio), 32'd250);
    check("rt_ready", 32'(cfg_ready), 32'd0);
    check("rt_dprst", 32'(dp_rst), 32'd1);
    count_flush("flush_len_rt");
    wait_state(M_RUN, 5000);

    // rejected requests: low dec, zero phi, high dec
    send(32'd1000, 16'd4);
    check("rej4_err", 32'(cfg_err), 32'd1);
    check("rej4_dec", 32'(dec_ratio), 32'd250);
    @(posedge clk); #1;
    check("rej4_pulse", 32'(cfg_err), 32'd0);
    check("rej4_valid", 32'(demod_valid), 32'd1);
    send(32'd0, 16'd100);
    check("rej0_err", 32'(cfg_err), 32'd1);
    check("rej0_phi", phi_inc, 32'd171798692);
    check("rej0_ready", 32'(cfg_ready), 32'd1);
    send(32'd5, 16'd1025);
    check("rej1025_err", 32'(cfg_err), 32'd1);

    // MIN_DEC boundary accepted, then hold a request across flush/settle
    send(32'd7, 16'd8);
    check("min_dec", 32'(dec_ratio), 32'd8);
    x0 = xfers;
    cfg_valid = 1'b1;
    cfg_phi_inc = 32'd99;
    cfg_dec_ratio = 16'd1024;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        n++;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        done = 1'b1;
      end
    end
    check("hold_xfers", 32'(n), 32'd1);
    check("hold_model", 32'(xfers - x0), 32'd1);
    check("hold_dec", 32'(dec_ratio), 32'd1024);
    check("hold_phi", phi_inc, 32'd99);
    wait_state(M_RUN, 5000);

    // settle timeout with demod_clk stuck low
    dclk_run = 1'b0;
    @(posedge clk); #1;
    demod_clk_in = 1'b0;
    send(32'd343597384, 16'd125);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!dp_rst) done = 1'b1;
    end
    k = 0;
    while (!timeout_err && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd4096);
    check("tmo_dprst", 32'(dp_rst), 32'd1);
    check("tmo_dec", 32'(dec_ratio), 32'd125);
    dclk_run = 1'b1;
    wait_state(M_RUN, 5000);
    check("tmo_recover", 32'(demod_valid), 32'd1);

    // reset mid-settle after a retune
    send(32'd171798692, 16'd250);
    wait_state(M_SETTLE, 100);
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_dec", 32'(dec_ratio), 32'd125);
    check("mrst_phi", phi_inc, 32'd343597384);
    check("mrst_state", 32'(state_o), 32'd0);
    count_flush("flush_len_mrst");
    wait_state(M_RUN, 5000);
    check("mrst_valid", 32'(demod_valid), 32'd1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demod_ctrl.md
Name: demod_ctrl

Overview:
Sequencing and configuration controller for the AM demodulator datapath (NCO local oscillator, CIC decimator, serial FIR). Accepts retune requests (LO phase increment, CIC decimation ratio) over a valid/ready handshake. Performs a safe retune: holds the datapath in reset, applies the new configuration, then waits for the FIR output to settle before flagging demodulated samples valid. Sits beside the demodulator top level; drives the datapath reset and configuration inputs.

Parameters:
DEFAULT_PHI, 32'd343597384, phase increment applied out of reset (10 MHz LO)
DEFAULT_DEC, 16'd125, decimation ratio applied out of reset
MIN_DEC, 16'd8, smallest legal decimation ratio
MAX_DEC, 16'd1024, largest legal decimation ratio
FLUSH_CYCLES, 16, clk cycles dp_rst is held per flush
SETTLE_SAMPLES, 4, demod_clk rising edges discarded before output is valid
TIMEOUT, 4096, clk cycles allowed between demod_clk edges while settling

Ports:
clk  in  1  system clock (ADC rate)
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  retune request valid
cfg_ready  out  1  controller accepts a request
cfg_phi_inc  in  32  requested LO phase increment
cfg_dec_ratio  in  16  requested CIC decimation ratio
demod_clk_in  in  1  FIR output clock, treated as an asynchronous level
dp_rst  out  1  datapath reset to LO/CIC/FIR, active-high
phi_inc  out  32  applied LO phase increment
dec_ratio  out  16  applied CIC decimation ratio
demod_valid  out  1  demodulated output trustworthy
cfg_err  out  1  one-cycle pulse: request rejected
timeout_err  out  1  one-cycle pulse: settle timeout, retrying
state_o  out  2  current state (FLUSH=0, SETTLE=1, RUN=2)

Behaviour:
- Reset values: state FLUSH, dp_rst=1, phi_inc=DEFAULT_PHI, dec_ratio=DEFAULT_DEC, demod_valid=0, cfg_ready=0, cfg_err=0, timeout_err=0, counters 0, synchronizer flops 0.
- demod_clk_in passes through a 2-flop synchronizer plus an edge register. A rising edge is registered 3 clk cycles after the input rises.
- FLUSH: dp_rst=1. Counter counts clk cycles. After FLUSH_CYCLES cycles in FLUSH, go to SETTLE and clear counters. dp_rst therefore falls exactly FLUSH_CYCLES cycles after the edge that entered FLUSH, or after the first edge with rst low.
- SETTLE: dp_rst=0, demod_valid=0. Count detected demod_clk rising edges.
  - On the SETTLE_SAMPLES-th edge, go to RUN; demod_valid=1 from the next cycle.
  - The timeout counter resets on every detected edge. If it reaches TIMEOUT, pulse timeout_err for one cycle and return to FLUSH. The configuration is unchanged.
- RUN: demod_valid=1, cfg_ready=1. A transfer occurs when cfg_valid && cfg_ready on a clk edge.
  - Accepted request: cfg_dec_ratio is within [MIN_DEC, MAX_DEC] and cfg_phi_inc != 0. On the same edge, phi_inc and dec_ratio load the request, state goes to FLUSH, and demod_valid and cfg_ready fall.
  - Rejected request: cfg_err pulses for one cycle, outputs are unchanged, and the state stays RUN with cfg_ready still 1.
- cfg_ready=0 in FLUSH and SETTLE. Requests are not consumed there; the requester must hold cfg_valid.
- phi_inc and dec_ratio change only on an accepted transfer or on rst.
- rst mid-operation (any state): returns to the reset values on the next edge, including the default configuration.
- A demod_clk edge during FLUSH is ignored. The edge counter is cleared on FLUSH exit.
- cfg_err and timeout_err never assert in the same cycle (they are from different states).

Decomposition:
- Shared package demod_pkg holds:
  - state encoding constants (FLUSH/SETTLE/RUN);
  - DEFAULT_PHI and DEFAULT_DEC;
  - PHI_W=32 and DEC_W=16 width constants.
- Sub-module edge_sync: 2-flop synchronizer plus rising-edge pulse with synchronous reset, reusable for other cross-clock strobes (clk_25x, cic_out_clk).

Test Plan:
- Reset release → dp_rst stays 1 for exactly 16 cycles. With demod_clk toggling every 250 clk cycles, demod_valid rises 1 cycle after the 4th detected edge. phi_inc=343597384, dec_ratio=125.
- In RUN, request phi=171798692, dec=250 → cfg_ready drops on the accepting edge, outputs update on that edge, dp_rst=1 for 16 cycles, demod_valid returns after 4 edges.
- In RUN, request dec=4 (below MIN_DEC) → cfg_err pulses 1 cycle, outputs unchanged, demod_valid stays 1. Repeat with phi_inc=0 and expect the same response.
- Hold cfg_valid high from FLUSH through SETTLE → no transfer until RUN. Transfer occurs on the first RUN cycle; exactly one retune.
- demod_clk stuck low in SETTLE → timeout_err pulses at 4096 cycles, state goes to FLUSH with the configuration unchanged. Release demod_clk and check normal recovery.
- Assert rst for 1 cycle mid-SETTLE after a retune to dec=250 → dec_ratio returns to 125 and the full reset sequence repeats.
